n64_blur_estimator: RTL and testbench

Parametrised successor of the deblur estimator for the N64 video input path. It sits between the input sampling stage and the deblur/pixel-drop logic. Per frame, it decides whether the N64 VI applies horizontal blur by detecting gradient reversals at blurry pixel positions. Compared with the fixed block, it adds:
- configurable widths and thresholds;
- hysteresis on the decision;
- a three-way mode select;
- trend readout and a per-frame valid strobe.

---
 rtl/n64_blur_estimator_pkg.sv | 35 +++
 rtl/n64_blur_estimator_if.sv | 30 +++
 rtl/n64_gradient_cmp.sv | 23 ++
 rtl/n64_blur_estimator.sv | 164 ++++++++++++++++
 tb/tb_n64_blur_estimator.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/n64_blur_estimator_pkg.sv
// Shared definitions for the N64 blur estimator: mode encodings, sync-nibble
// bit positions and helpers for slicing the previous-pixel vector.
package n64_blur_estimator_pkg;

    // Deblur mode select; both 00 and 11 mean "follow the estimate"
    typedef enum logic [1:0] {
        MODE_AUTO      = 2'b00,
        MODE_FORCE_ON  = 2'b01,
        MODE_FORCE_OFF = 2'b10,
        MODE_AUTO_ALT  = 2'b11
    } mode_e;

    // Bit positions inside the sync nibble {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
    localparam int SYNC_NVSYNC_BIT = 3;
    localparam int SYNC_NHSYNC_BIT = 1;

    // Channel numbering used inside the estimator: 0 = R, 1 = G, 2 = B
    localparam int NUM_CH = 3;

    // LSB of a colour channel inside {sync, R, G, B}
    function automatic int chan_lsb(input int color_width, input int ch);
        return (2 - ch) * color_width;
    endfunction

    // LSB of the sync nibble inside {sync, R, G, B}
    function automatic int sync_lsb(input int color_width);
        return 3 * color_width;
    endfunction

    // Number of channels that showed a gradient reversal
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/n64_blur_estimator_if.sv
// Pixel-bus side and decision outputs of the blur estimator. The master
// modport is the sampling stage feeding the bus; the slave is the estimator.
interface n64_blur_estimator_if #(
    parameter int COLOR_WIDTH = 7,
    parameter int TREND_WIDTH = 9
);
    logic                       nDSYNC;
    logic [3*COLOR_WIDTH+3:0]   vdata_pre;
    logic [COLOR_WIDTH-1:0]     vdata_cur;
    logic [1:0]                 data_cnt;
    logic                       n64_480i;
    logic                       blurry_pixel_pos;
    logic [1:0]                 mode;
    logic                       ndo_deblur;
    logic                       nblur_n64;
    logic [TREND_WIDTH-1:0]     trend_o;
    logic                       est_valid;

    modport master (
        output nDSYNC, vdata_pre, vdata_cur, data_cnt, n64_480i,
               blurry_pixel_pos, mode,
        input  ndo_deblur, nblur_n64, trend_o, est_valid
    );

    modport slave (
        input  nDSYNC, vdata_pre, vdata_cur, data_cnt, n64_480i,
               blurry_pixel_pos, mode,
        output ndo_deblur, nblur_n64, trend_o, est_valid
    );
endinterface

// File: rtl/n64_gradient_cmp.sv
// Two-bit gradient of one colour channel between the previous and current
// pixel, looking only at the upper slice so dithering noise is ignored.
// grad = {rising, falling}; 00 means "no significant change".
module n64_gradient_cmp #(
    parameter int COLOR_WIDTH = 7,
    parameter int CMP_MSB     = 6,
    parameter int CMP_LSB     = 5
) (
    input  logic [COLOR_WIDTH-1:0] pre,
    input  logic [COLOR_WIDTH-1:0] cur,
    output logic [1:0]             grad
);
    logic [CMP_MSB-CMP_LSB:0] pre_s;
    logic [CMP_MSB-CMP_LSB:0] cur_s;
    logic                     unused_low;

    assign pre_s = pre[CMP_MSB:CMP_LSB];
    assign cur_s = cur[CMP_MSB:CMP_LSB];
    assign grad  = {pre_s < cur_s, pre_s > cur_s};

    // Bits below the compared slice are intentionally ignored
    assign unused_low = ^{pre, cur};
endmodule

// File: rtl/n64_blur_estimator.sv
// Per-frame horizontal blur estimator for the N64 video input path.
// Counts strict gradient reversals at blurry pixel positions, filters the
// per-frame result into a saturating trend and derives the deblur decision
// with hysteresis. All state moves on the falling edge of nCLK.
// CMP_MSB is expected to equal COLOR_WIDTH-1.
module n64_blur_estimator
    import n64_blur_estimator_pkg::*;
#(
    parameter int COLOR_WIDTH   = 7,
    parameter int CMP_MSB       = 6,
    parameter int CMP_LSB       = 5,
    parameter int MIN_CH        = 3,
    parameter int EST_CNT_WIDTH = 2,
    parameter int HOLDOFF_WIDTH = 2,
    parameter int TREND_WIDTH   = 9,
    parameter int INIT_TREND    = 2 ** (TREND_WIDTH - 1),
    parameter int TH_SET        = 2 ** (TREND_WIDTH - 1),
    parameter int TH_CLR        = 2 ** (TREND_WIDTH - 1)
) (
    input logic                 nCLK,
    input logic                 nRST,
    n64_blur_estimator_if.slave bus
);
    localparam int SYNC_LSB = sync_lsb(COLOR_WIDTH);
    localparam logic [EST_CNT_WIDTH-1:0] EST_MAX   = '1;
    localparam logic [TREND_WIDTH-1:0]   TREND_MAX = '1;

    logic [NUM_CH-1:0][1:0]     g_now;
    logic [NUM_CH-1:0][1:0]     grad;
    logic [NUM_CH-1:0]          flip;
    logic [EST_CNT_WIDTH-1:0]   est_cnt;
    logic [HOLDOFF_WIDTH-1:0]   holdoff;
    logic [TREND_WIDTH-1:0]     trend;
    logic                       run;
    logic                       nblur;
    logic                       ndo;
    logic                       valid;
    logic                       sel;
    logic                       active;
    logic                       sync_phase;
    logic                       vsync_fall;
    logic                       hsync_fall;
    logic                       hit;
    logic [1:0]                 ch_sel;
    logic                       unused_sync;

    // One comparator per channel, each against its own slice of the old pixel
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cmp
        localparam int LSB = chan_lsb(COLOR_WIDTH, ch);
        n64_gradient_cmp #(
            .COLOR_WIDTH(COLOR_WIDTH),
            .CMP_MSB    (CMP_MSB),
            .CMP_LSB    (CMP_LSB)
        ) u_cmp (
            .pre (bus.vdata_pre[LSB +: COLOR_WIDTH]),
            .cur (bus.vdata_cur),
            .grad(g_now[ch])
        );
    end

    assign active     = ~bus.n64_480i;
    assign sync_phase = ~bus.nDSYNC;
    assign ch_sel     = bus.data_cnt - 2'd1;
    assign hit        = popcount3(flip) >= 2'(MIN_CH);
    assign vsync_fall = sync_phase & bus.vdata_pre[SYNC_LSB + SYNC_NVSYNC_BIT]
                        & ~bus.vdata_cur[SYNC_NVSYNC_BIT];
    assign hsync_fall = sync_phase & bus.vdata_pre[SYNC_LSB + SYNC_NHSYNC_BIT]
                        & ~bus.vdata_cur[SYNC_NHSYNC_BIT];
    assign unused_sync = bus.vdata_pre[SYNC_LSB + 2] ^ bus.vdata_pre[SYNC_LSB];

    // Remember the reference gradient, flag strict reversals, clear per pixel
    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            grad <= '0;
            flip <= '0;
        end else if (active) begin
            if (bus.nDSYNC) begin
                if (bus.data_cnt != 2'd0) begin
                    if (bus.blurry_pixel_pos)
                        grad[ch_sel] <= g_now[ch_sel];
                    else if (&(grad[ch_sel] ^ g_now[ch_sel]))
                        flip[ch_sel] <= 1'b1;
                end
            end else if (!bus.blurry_pixel_pos) begin
                flip <= '0;
            end
        end
    end

    // Count hits per frame; hold-off suppresses hits that follow too closely
    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            holdoff <= '0;
            est_cnt <= '0;
        end else if (active && sync_phase) begin
            if (!bus.blurry_pixel_pos) begin
                if (holdoff != '0)
                    holdoff <= holdoff + 1'b1;
                if (hit) begin
                    if (est_cnt != EST_MAX && holdoff == '0)
                        est_cnt <= est_cnt + 1'b1;
                    holdoff <= HOLDOFF_WIDTH'(1);
                end
            end
            if (hsync_fall)
                holdoff <= '0;
            if (vsync_fall)
                est_cnt <= '0;
        end
    end

    // Frame boundary: filter into the trend, decide with hysteresis
    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            trend <= TREND_WIDTH'(INIT_TREND);
            nblur <= 1'b1;
            valid <= 1'b0;
            run   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!active) begin
                run <= 1'b0;
            end else if (vsync_fall) begin
                if (run) begin
                    if (est_cnt == EST_MAX) begin
                        if (trend != TREND_MAX)
                            trend <= trend + 1'b1;
                    end else if (trend != '0) begin
                        trend <= trend - 1'b1;
                    end
                end
                if (trend >= TREND_WIDTH'(TH_SET))
                    nblur <= 1'b1;
                else if (trend < TREND_WIDTH'(TH_CLR))
                    nblur <= 1'b0;
                valid <= 1'b1;
                run   <= 1'b1;
            end
        end
    end

    // Pick the deblur source from the mode input
    always_comb begin
        sel = nblur;
        case (bus.mode)
            MODE_FORCE_ON:  sel = 1'b0;
            MODE_FORCE_OFF: sel = 1'b1;
            default:        sel = nblur;
        endcase
    end

    // Deblur control only changes at a frame boundary, even in 480i
    always_ff @(negedge nCLK) begin
        if (!nRST)
            ndo <= 1'b1;
        else if (vsync_fall)
            ndo <= bus.n64_480i | sel;
    end

    assign bus.trend_o    = trend;
    assign bus.nblur_n64  = nblur;
    assign bus.ndo_deblur = ndo;
    assign bus.est_valid  = valid;
endmodule

// File: tb/tb_n64_blur_estimator.sv
// Directed bench for n64_blur_estimator: one default-threshold instance and
// one with a hysteresis band (0xFC..0x104), both fed the same pixel stream.
module tb_n64_blur_estimator;
    logic        nclk;
    logic        nrst;
    logic        ndsync;
    logic [24:0] vdata_pre;
    logic [6:0]  vdata_cur;
    logic [1:0]  data_cnt;
    logic        n64_480i;
    logic        bpp;
    logic [1:0]  mode;

    int vectors;
    int miscompares;

    n64_blur_estimator_if bus_a ();
    n64_blur_estimator_if bus_h ();

    assign bus_a.nDSYNC           = ndsync;
    assign bus_a.vdata_pre        = vdata_pre;
    assign bus_a.vdata_cur        = vdata_cur;
    assign bus_a.data_cnt         = data_cnt;
    assign bus_a.n64_480i         = n64_480i;
    assign bus_a.blurry_pixel_pos = bpp;
    assign bus_a.mode             = mode;
    assign bus_h.nDSYNC           = ndsync;
    assign bus_h.vdata_pre        = vdata_pre;
    assign bus_h.vdata_cur        = vdata_cur;
    assign bus_h.data_cnt         = data_cnt;
    assign bus_h.n64_480i         = n64_480i;
    assign bus_h.blurry_pixel_pos = bpp;
    assign bus_h.mode             = mode;

    n64_blur_estimator dut_a (
        .nCLK(nclk),
        .nRST(nrst),
        .bus (bus_a.slave)
    );

    n64_blur_estimator #(
        .TH_SET(32'h104),
        .TH_CLR(32'h0FC)
    ) dut_h (
        .nCLK(nclk),
        .nRST(nrst),
        .bus (bus_h.slave)
    );

    initial nclk = 1'b0;
    always #5 nclk = ~nclk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one bus word; it is sampled at the following falling edge
    task automatic cyc(input logic ds, input logic [1:0] cnt, input logic [24:0] pre,
                       input logic [6:0] cur, input logic b);
        @(posedge nclk);
        ndsync    = ds;
        data_cnt  = cnt;
        vdata_pre = pre;
        vdata_cur = cur;
        bpp       = b;
    endtask

    task automatic pixel(input logic [3:0] sync, input logic [6:0] pre_c,
                         input logic [6:0] cur_c, input logic b);
        logic [24:0] pre;
        pre = {4'hF, pre_c, pre_c, pre_c};
        cyc(1'b0, 2'd0, pre, {3'b000, sync}, b);
        cyc(1'b1, 2'd1, pre, cur_c, b);
        cyc(1'b1, 2'd2, pre, cur_c, b);
        cyc(1'b1, 2'd3, pre, cur_c, b);
    endtask

    task automatic ref_px();
        pixel(4'hF, 7'h00, 7'h7F, 1'b1);
    endtask

    task automatic rev_px();
        pixel(4'hF, 7'h7F, 7'h00, 1'b0);
    endtask

    task automatic neu_px(input logic [3:0] sync);
        pixel(sync, 7'h00, 7'h00, 1'b0);
    endtask

    // Reference, reversing pixel, then four quiet pixels so hold-off expires
    task automatic hit_group();
        ref_px();
        rev_px();
        for (int k = 0; k < 4; k++) neu_px(4'hF);
    endtask

    task automatic frame_body(input int nhits);
        neu_px(4'hF);
        for (int k = 0; k < nhits; k++) hit_group();
        neu_px(4'hF);
    endtask

    // nVSYNC falling edge, then sample just after the edge that sees it
    task automatic vsync_cycle();
        cyc(1'b0, 2'd0, {4'hF, 21'h0}, 7'h07, 1'b0);
        @(negedge nclk);
        #1;
    endtask

    task automatic frame(input int nhits);
        frame_body(nhits);
        vsync_cycle();
    endtask

    task automatic test_reset();
        nrst = 1'b0; ndsync = 1'b0; data_cnt = 2'd0; vdata_pre = {4'hF, 21'h0};
        vdata_cur = 7'h0F; n64_480i = 1'b0; bpp = 1'b0; mode = 2'b00;
        repeat (8) @(posedge nclk);
        vectors++;
        if (bus_a.trend_o !== 9'h100) begin miscompares++; $display("[TB] FAIL reset trend_o: got %h expected 100", bus_a.trend_o); end
        vectors++;
        if (bus_a.nblur_n64 !== 1'b1) begin miscompares++; $display("[TB] FAIL reset nblur_n64: got %b expected 1", bus_a.nblur_n64); end
        vectors++;
        if (bus_a.ndo_deblur !== 1'b1) begin miscompares++; $display("[TB] FAIL reset ndo_deblur: got %b expected 1", bus_a.ndo_deblur); end
        vectors++;
        if (bus_a.est_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset est_valid: got %b expected 0", bus_a.est_valid); end
        vectors++;
        if (bus_h.trend_o !== 9'h100) begin miscompares++; $display("[TB] FAIL reset trend_h: got %h expected 100", bus_h.trend_o); end
        nrst = 1'b1;
    endtask

    // Trend walks down, up past the threshold and back down again
    task automatic test_trend_hysteresis();
        int         hits [11];
        logic [8:0] exp_trend [11];
        logic       exp_nblur [11];
        logic       exp_ndo [11];
        hits      = '{0, 0, 0, 3, 3, 3, 3, 0, 0, 0, 0};
        exp_trend = '{9'h100, 9'h0FF, 9'h0FE, 9'h0FF, 9'h100, 9'h101,
                      9'h102, 9'h101, 9'h100, 9'h0FF, 9'h0FE};
        exp_nblur = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        exp_ndo   = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        for (int i = 0; i < 11; i++) begin
            frame(hits[i]);
            vectors++;
            if (bus_a.trend_o !== exp_trend[i]) begin miscompares++; $display("[TB] FAIL frame%0d trend_o: got %h expected %h", i + 1, bus_a.trend_o, exp_trend[i]); end
            vectors++;
            if (bus_a.nblur_n64 !== exp_nblur[i]) begin miscompares++; $display("[TB] FAIL frame%0d nblur_n64: got %b expected %b", i + 1, bus_a.nblur_n64, exp_nblur[i]); end
            vectors++;
            if (bus_a.ndo_deblur !== exp_ndo[i]) begin miscompares++; $display("[TB] FAIL frame%0d ndo_deblur: got %b expected %b", i + 1, bus_a.ndo_deblur, exp_ndo[i]); end
            vectors++;
            if (bus_a.est_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL frame%0d est_valid: got %b expected 1", i + 1, bus_a.est_valid); end
            vectors++;
            if (bus_h.trend_o !== exp_trend[i]) begin miscompares++; $display("[TB] FAIL frame%0d trend_h: got %h expected %h", i + 1, bus_h.trend_o, exp_trend[i]); end
            vectors++;
            if (bus_h.nblur_n64 !== 1'b1) begin miscompares++; $display("[TB] FAIL frame%0d nblur_h: got %b expected 1", i + 1, bus_h.nblur_n64); end
            if (i == 0) begin
                cyc(1'b0, 2'd0, {4'hF, 21'h0}, 7'h0F, 1'b0);
                @(negedge nclk);
                #1;
                vectors++;
                if (bus_a.est_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL strobe_width est_valid: got %b expected 0", bus_a.est_valid); end
            end
        end
    endtask

    // Close hits are suppressed until hold-off expires or HSYNC clears it
    task automatic test_holdoff();
        for (int f = 0; f < 2; f++) begin
            neu_px(4'hF);
            ref_px(); rev_px(); neu_px(4'hF);
            ref_px(); rev_px(); neu_px(4'hF);
            neu_px(4'hD);
            ref_px(); rev_px(); neu_px(4'hF);
            for (int k = 0; k < 4; k++) neu_px(4'hF);
            if (f == 1) hit_group();
            neu_px(4'hF);
            vsync_cycle();
            vectors++;
            if (bus_a.trend_o !== (f == 0 ? 9'h0FD : 9'h0FE)) begin miscompares++; $display("[TB] FAIL holdoff%0d trend_o: got %h expected %h", f, bus_a.trend_o, (f == 0 ? 9'h0FD : 9'h0FE)); end
        end
        vectors++;
        if (bus_a.nblur_n64 !== 1'b0) begin miscompares++; $display("[TB] FAIL holdoff nblur_n64: got %b expected 0", bus_a.nblur_n64); end
        vectors++;
        if (bus_h.nblur_n64 !== 1'b1) begin miscompares++; $display("[TB] FAIL holdoff nblur_h: got %b expected 1", bus_h.nblur_n64); end
    endtask

    task automatic test_interlace();
        n64_480i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frame(3);
            vectors++;
            if (bus_a.trend_o !== 9'h0FE) begin miscompares++; $display("[TB] FAIL 480i%0d trend_o: got %h expected 0fe", i, bus_a.trend_o); end
            vectors++;
            if (bus_a.ndo_deblur !== 1'b1) begin miscompares++; $display("[TB] FAIL 480i%0d ndo_deblur: got %b expected 1", i, bus_a.ndo_deblur); end
        end
        n64_480i = 1'b0;
        frame(3);
        vectors++;
        if (bus_a.trend_o !== 9'h0FE) begin miscompares++; $display("[TB] FAIL 240p_first trend_o: got %h expected 0fe", bus_a.trend_o); end
        vectors++;
        if (bus_a.ndo_deblur !== 1'b0) begin miscompares++; $display("[TB] FAIL 240p_first ndo_deblur: got %b expected 0", bus_a.ndo_deblur); end
        frame(3);
        vectors++;
        if (bus_a.trend_o !== 9'h0FF) begin miscompares++; $display("[TB] FAIL 240p_second trend_o: got %h expected 0ff", bus_a.trend_o); end
    endtask

    // Mode changes mid-frame only take effect at the next nVSYNC edge
    task automatic test_mode();
        logic [1:0] new_mode [4];
        logic       mid_ndo [4];
        logic       end_ndo [4];
        new_mode = '{2'b10, 2'b01, 2'b01, 2'b00};
        mid_ndo  = '{0, 1, 0, 0};
        end_ndo  = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            neu_px(4'hF);
            hit_group();
            mode = new_mode[i];
            hit_group();
            hit_group();
            vectors++;
            if (bus_a.ndo_deblur !== mid_ndo[i]) begin miscompares++; $display("[TB] FAIL mode%0d_mid ndo_deblur: got %b expected %b", i, bus_a.ndo_deblur, mid_ndo[i]); end
            neu_px(4'hF);
            vsync_cycle();
            vectors++;
            if (bus_a.ndo_deblur !== end_ndo[i]) begin miscompares++; $display("[TB] FAIL mode%0d_vsync ndo_deblur: got %b expected %b", i, bus_a.ndo_deblur, end_ndo[i]); end
        end
        vectors++;
        if (bus_a.nblur_n64 !== 1'b1) begin miscompares++; $display("[TB] FAIL mode nblur_n64: got %b expected 1", bus_a.nblur_n64); end
    endtask

    task automatic test_reset_midframe();
        neu_px(4'hF);
        hit_group();
        ref_px();
        rev_px();
        @(posedge nclk);
        nrst = 1'b0;
        @(posedge nclk);
        nrst = 1'b1;
        vectors++;
        if (bus_a.trend_o !== 9'h100) begin miscompares++; $display("[TB] FAIL midreset trend_o: got %h expected 100", bus_a.trend_o); end
        vectors++;
        if (bus_a.nblur_n64 !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset nblur_n64: got %b expected 1", bus_a.nblur_n64); end
        vectors++;
        if (bus_a.ndo_deblur !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset ndo_deblur: got %b expected 1", bus_a.ndo_deblur); end
        frame(3);
        vectors++;
        if (bus_a.trend_o !== 9'h100) begin miscompares++; $display("[TB] FAIL post_reset_frame trend_o: got %h expected 100", bus_a.trend_o); end
        vectors++;
        if (bus_a.est_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_frame est_valid: got %b expected 1", bus_a.est_valid); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        $display("[TB] reset checked");
        test_trend_hysteresis();
        $display("[TB] trend and hysteresis frames done");
        test_holdoff();
        $display("[TB] hold-off frames done");
        test_interlace();
        $display("[TB] interlace frames done");
        test_mode();
        $display("[TB] mode frames done");
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
